yarp_mem_arbiter: RTL

Shares the single memory port between the instruction-fetch requester and the data load/store requester. It arbitrates requests and holds the winning request stable until memory grants it. It tracks in-order outstanding transactions in a small ID FIFO and routes each response back to the requester that issued it. It sits between the fetch/LSU stages and the unified memory.

---
 rtl/yarp_mem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/yarp_mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data load/store,
// tracks in-order outstanding IDs and steers each response back to its requester.
module yarp_mem_arbiter #(
   parameter int MAX_OUT      = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   input  logic        dm_req_i,
   input  logic [31:0] dm_addr_i,
   input  logic        dm_we_i,
   input  logic [3:0]  dm_be_i,
   input  logic [31:0] dm_wdata_i,
   output logic        dm_gnt_o,
   output logic        dm_rvalid_o,
   output logic [31:0] dm_rdata_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        err_o
);

   logic [2:0] r_count;
   logic [1:0] r_wptr;
   logic [1:0] r_rptr;
   logic [3:0] r_fifo;
   logic [3:0] r_starve;
   logic       r_lock_vld;
   logic       r_lock_id;
   logic       r_err;

   logic       w_avail;
   logic       w_lock_hold;
   logic       w_retract;
   logic       w_win_dm;
   logic       w_grant;
   logic       w_head;
   logic       w_empty;
   logic       w_push;
   logic       w_pop;
   logic       w_rsp_err;

   // Capacity, lock tracking and winner selection (ID 1 = data, 0 = fetch)
   always_comb begin
      w_avail     = (r_count < 3'(MAX_OUT));
      w_lock_hold = r_lock_vld && (r_lock_id ? dm_req_i : if_req_i);
      w_retract   = r_lock_vld && !w_lock_hold;
      if (w_lock_hold) begin
         w_win_dm = r_lock_id;
      end else begin
         w_win_dm = dm_req_i && !(if_req_i && (r_starve >= 4'(STARVE_LIMIT)));
      end
      mem_req_o = w_avail && (if_req_i || dm_req_i) && !reset;
      w_grant   = mem_req_o && mem_gnt_i;
      if_gnt_o  = w_grant && !w_win_dm;
      dm_gnt_o  = w_grant && w_win_dm;
   end

   // Memory request mux: fetch is always a full-word read
   always_comb begin
      if (w_win_dm) begin
         mem_addr_o  = dm_addr_i;
         mem_we_o    = dm_we_i;
         mem_be_o    = dm_be_i;
         mem_wdata_o = dm_wdata_i;
      end else begin
         mem_addr_o  = if_addr_i;
         mem_we_o    = 1'b0;
         mem_be_o    = 4'hF;
         mem_wdata_o = 32'h0000_0000;
      end
   end

   // Response routing from the FIFO head; responses with no outstanding ID are dropped
   always_comb begin
      w_empty     = (r_count == 3'd0);
      w_head      = r_fifo[r_rptr];
      w_push      = w_grant;
      w_pop       = mem_rvalid_i && !w_empty;
      w_rsp_err   = mem_rvalid_i && w_empty;
      if_rvalid_o = w_pop && !w_head && !reset;
      dm_rvalid_o = w_pop && w_head && !reset;
      if_rdata_o  = mem_rdata_i;
      dm_rdata_o  = mem_rdata_i;
      err_o       = r_err;
   end

   // Outstanding-ID FIFO, lock, starvation counter and sticky error
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count    <= 3'd0;
         r_wptr     <= 2'd0;
         r_rptr     <= 2'd0;
         r_fifo     <= 4'b0000;
         r_starve   <= 4'd0;
         r_lock_vld <= 1'b0;
         r_lock_id  <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= w_win_dm;
            r_wptr <= (r_wptr == 2'(MAX_OUT - 1)) ? 2'd0 : r_wptr + 2'd1;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == 2'(MAX_OUT - 1)) ? 2'd0 : r_rptr + 2'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase

         if (mem_req_o && !mem_gnt_i) begin
            r_lock_vld <= 1'b1;
            r_lock_id  <= w_win_dm;
         end else begin
            r_lock_vld <= 1'b0;
            r_lock_id  <= 1'b0;
         end

         if (if_gnt_o) begin
            r_starve <= 4'd0;
         end else if (if_req_i && dm_gnt_o && (r_starve < 4'(STARVE_LIMIT))) begin
            r_starve <= r_starve + 4'd1;
         end else begin
            r_starve <= r_starve;
         end

         if (w_rsp_err || w_retract) begin
            r_err <= 1'b1;
         end else begin
            r_err <= r_err;
         end
      end
   end

endmodule
